// File: rtl/bubble_controller.sv
// Bubble projectile manager: four slots rise once per frame, and a new bubble
// spawns from the sub on fire requests, rate-limited by a cooldown.
module bubble_controller #(
  parameter int RISE_STEP = 2,
  parameter int TOP_LIMIT = 16,
  parameter int SPAWN_DY  = -10,
  parameter int COOLDOWN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               fire_req,
  input  logic signed [11:0] subX,
  input  logic signed [11:0] subY,
  output logic               fire_ack,
  output logic [47:0]        bubX,
  output logic [47:0]        bubY,
  output logic [3:0]         bub_active,
  output logic               busy
);

  localparam int unsigned COORD_W = 12;
  localparam int unsigned SLOTS   = 4;
  localparam int unsigned CD_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic signed [COORD_W-1:0] RISE_Y  = COORD_W'(RISE_STEP);
  localparam logic signed [COORD_W-1:0] TOP_Y   = COORD_W'(TOP_LIMIT);
  localparam logic signed [COORD_W-1:0] SPAWN_Y = COORD_W'(SPAWN_DY);
  localparam logic [CD_W-1:0]           CD_LOAD = CD_W'(COOLDOWN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_SPAWN = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [1:0]                    idx_q, idx_d;
  logic [SLOTS-1:0][COORD_W-1:0] bub_x_q, bub_x_d;
  logic [SLOTS-1:0][COORD_W-1:0] bub_y_q, bub_y_d;
  logic [SLOTS-1:0]              active_q, active_d;
  logic [CD_W-1:0]               cooldown_q, cooldown_d;
  logic                          pending_q, pending_d;
  logic                          fire_ack_q, fire_ack_d;
  logic                          busy_q, busy_d;

  logic signed [COORD_W-1:0]     y_new;
  logic [1:0]                    spawn_idx;
  logic                          slot_free;

  // Lowest-index free slot for a spawn
  always_comb begin
    spawn_idx = 2'd0;
    slot_free = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        spawn_idx = 2'(i);
        slot_free = 1'b1;
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bub_x_d    = bub_x_q;
    bub_y_d    = bub_y_q;
    active_d   = active_q;
    cooldown_d = cooldown_q;
    pending_d  = pending_q;
    fire_ack_d = 1'b0;
    y_new      = bub_y_q[idx_q] - RISE_Y;

    // A request arriving in the ack cycle is treated as part of the one just served
    if (fire_req && !fire_ack_q) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_MOVE;
          idx_d   = 2'd0;
        end
      end
      S_MOVE: begin
        if (active_q[idx_q]) begin
          if (y_new < TOP_Y) begin
            active_d[idx_q] = 1'b0;
          end else begin
            bub_y_d[idx_q] = y_new;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = S_SPAWN;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_SPAWN: begin
        state_d = S_IDLE;
        if (cooldown_q != '0) begin
          cooldown_d = cooldown_q - CD_W'(1);
        end else if (pending_q && slot_free) begin
          bub_x_d[spawn_idx]  = subX;
          bub_y_d[spawn_idx]  = subY + SPAWN_Y;
          active_d[spawn_idx] = 1'b1;
          fire_ack_d          = 1'b1;
          cooldown_d          = CD_LOAD;
          pending_d           = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      bub_x_q    <= '0;
      bub_y_q    <= '0;
      active_q   <= '0;
      cooldown_q <= '0;
      pending_q  <= 1'b0;
      fire_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bub_x_q    <= bub_x_d;
      bub_y_q    <= bub_y_d;
      active_q   <= active_d;
      cooldown_q <= cooldown_d;
      pending_q  <= pending_d;
      fire_ack_q <= fire_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign fire_ack   = fire_ack_q;
  assign bubX       = bub_x_q;
  assign bubY       = bub_y_q;
  assign bub_active = active_q;
  assign busy       = busy_q;

endmodule

// File: doc/bubble_controller.md
BUBBLE_CONTROLLER -- requirements
Module: bubble_controller

Interface
REQ-001 The block SHALL have parameter RISE_STEP, default 2, meaning pixels each active bubble rises per frame.
REQ-002 The block SHALL have parameter TOP_LIMIT, default 16, meaning the signed Y below which a bubble is retired.
REQ-003 The block SHALL have parameter SPAWN_DY, default -10, meaning the signed Y offset from the sub at spawn.
REQ-004 The block SHALL have parameter COOLDOWN, default 8, meaning the minimum frames between spawns.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port frame_tick, input, 1 bit, a one-cycle pulse once per frame during blanking.
REQ-008 The block SHALL have port fire_req, input, 1 bit, a player fire request pulse or level.
REQ-009 The block SHALL have ports subX and subY, input, signed 12 bits each, the sub position.
REQ-010 The block SHALL have port fire_ack, output, 1 bit, a one-cycle pulse when a bubble is spawned.
REQ-011 The block SHALL have ports bubX and bubY, output, 48 bits each, four signed 12-bit slots packed with slot i in bits [12i+11:12i], in drawBubble coordinate format.
REQ-012 The block SHALL have port bub_active, output, 4 bits, where bit i is set while slot i is live.
REQ-013 The block SHALL have port busy, output, 1 bit, high while the frame update sequence runs.

Function
REQ-014 The FSM SHALL have states IDLE, MOVE and SPAWN, and all outputs SHALL be registered.
REQ-015 In IDLE, a frame_tick SHALL move the FSM to MOVE with slot index 0; otherwise the FSM SHALL stay in IDLE.
REQ-016 In MOVE, exactly one slot SHALL be processed per cycle, in order 0 to 3.
REQ-017 An active slot processed in MOVE SHALL take Ynew = Y - RISE_STEP in 12-bit signed arithmetic.
REQ-018 If Ynew < TOP_LIMIT (signed compare), the slot SHALL have its bub_active bit cleared and its X/Y held unchanged; otherwise Y SHALL become Ynew.
REQ-019 An inactive slot processed in MOVE SHALL be left unchanged.
REQ-020 After slot 3 is processed, the FSM SHALL go to SPAWN.
REQ-021 SPAWN SHALL last one cycle and then return to IDLE.
REQ-022 In SPAWN, if the cooldown counter is nonzero, it SHALL decrement by 1 and no spawn SHALL occur.
REQ-023 In SPAWN, if the cooldown is 0, a fire request is pending and at least one slot is free, the lowest-index free slot SHALL load X=subX, Y=subY+SPAWN_DY (truncated to 12 bits) and set its active bit.
REQ-024 On a spawn, fire_ack SHALL be high for exactly the cycle after SPAWN, the cooldown SHALL load COOLDOWN, and the pending flag SHALL clear.
REQ-025 If all four slots are active in SPAWN, the fire request SHALL remain pending and the cooldown SHALL remain unchanged.
REQ-026 A pending flag SHALL be set by fire_req high in any cycle, except that fire_req in the fire_ack cycle SHALL be dropped.
REQ-027 frame_tick arriving while busy SHALL be ignored, with no queuing.
REQ-028 Timing SHALL be as follows for a tick sampled at cycle T: MOVE runs T+1..T+4; slot i update is visible at T+2+i; SPAWN occurs at T+5; fire_ack and the new slot are visible at T+6; busy is high T+1..T+5.
REQ-029 A slot retired in MOVE SHALL be available for a spawn in the SPAWN state of the same frame.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL set state to IDLE, index 0, bub_active=0, bubX=0, bubY=0, cooldown=0, pending=0, fire_ack=0 and busy=0.
REQ-031 Reset asserted mid-sequence (in MOVE or SPAWN) SHALL abort the sequence with no partial spawn and no fire_ack.
REQ-032 rst SHALL take priority over frame_tick and fire_req in the same cycle.

Verification
REQ-033 The bench SHALL check: reset, then subX=100, subY=200, fire_req pulse, then frame_tick -> fire_ack at T+6, slot0=(100,190), bub_active=0001.
REQ-034 The bench SHALL check: slot0 at Y=190 with five further ticks -> Y=180, and 3 valid spawn requests made during the cooldown window are not acked until the frame in which the cooldown counter reaches 0.
REQ-035 The bench SHALL check: slot at Y=17 with RISE_STEP=2 -> one tick gives Ynew=15<16, the active bit clears and Y stays 17.
REQ-036 The bench SHALL check: four slots active, fire pending, cooldown 0 -> no ack and the request stays pending; after slot 2 retires, the next SPAWN fills slot 2 and fire_ack pulses.
REQ-037 The bench SHALL check: frame_tick at T and at T+3 -> the second tick is ignored, each active Y decrements once only, and busy drops at T+6.
REQ-038 The bench SHALL check: rst asserted at T+5 (SPAWN) with fire pending -> no fire_ack, and all outputs are zero at T+6.
